// File: rtl/clock_ctrl_pkg.sv
// Shared encodings for the digital-clock mode controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package clock_ctrl_pkg;

  // Width of the externally visible mode/state field.
  localparam int MODE_W = 2;

  // Mode FSM encodings; these values are visible on the mode output.
  localparam logic [MODE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [MODE_W-1:0] ST_RUN     = 2'd1;
  localparam logic [MODE_W-1:0] ST_SET_MIN = 2'd2;
  localparam logic [MODE_W-1:0] ST_SET_HR  = 2'd3;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for an already-synchronous pushbutton level.
// Latency: edge is combinational in the cycle the input first reads 1.
// Backpressure: none; a held button yields a single edge.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_in,
  output logic o_edge
);

  logic r_q;

  // Remember last cycle's button level so a held press is seen only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_in;
    end
  end

  assign o_edge = i_in & ~r_q;

endmodule

// File: rtl/clock_mode_controller.sv
// Mode FSM and 1 Hz prescaler issuing command pulses to the time counters.
// Latency: every output is registered; a button edge acts one cycle later.
// Backpressure: none; pulses are single-cycle and must be taken when issued.
module clock_mode_controller
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_DIV       = 50000000,
  parameter int TIMEOUT_TICKS = 10,
  parameter int DIV_W         = $clog2(CLK_DIV),
  parameter int TO_W          = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode_btn,
  input  logic              inc_btn,
  input  logic              clr_btn,
  output logic              tick_1hz,
  output logic              min_inc,
  output logic              hr_inc,
  output logic              sec_clr,
  output logic [MODE_W-1:0] mode,
  output logic              running
);

  // Last prescaler value of a second, and the idle-second count that ends a SET state.
  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_TICKS);

  // Button edges.
  logic w_mode_edge;
  logic w_inc_edge;
  logic w_clr_edge;

  // State.
  logic [MODE_W-1:0] r_state;
  logic [DIV_W-1:0]  r_presc;
  logic [TO_W-1:0]   r_to;

  // Registered command outputs.
  logic r_tick;
  logic r_min_inc;
  logic r_hr_inc;
  logic r_sec_clr;
  logic r_running;

  // Next-state values.
  logic [MODE_W-1:0] w_state_nxt;
  logic [DIV_W-1:0]  w_presc_nxt;
  logic [TO_W-1:0]   w_to_nxt;
  logic              w_tick_nxt;
  logic              w_min_nxt;
  logic              w_hr_nxt;
  logic              w_clr_nxt;

  // Prescaler helpers.
  logic              w_wrap;
  logic [DIV_W-1:0]  w_presc_adv;
  logic [TO_W-1:0]   w_to_inc;

  rise_edge_detect u_mode_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_in   (mode_btn),
    .o_edge (w_mode_edge)
  );

  rise_edge_detect u_inc_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_in   (inc_btn),
    .o_edge (w_inc_edge)
  );

  rise_edge_detect u_clr_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_in   (clr_btn),
    .o_edge (w_clr_edge)
  );

  assign w_wrap      = (r_presc == PRESC_MAX);
  assign w_presc_adv = w_wrap ? '0 : r_presc + 1'b1;
  assign w_to_inc    = r_to + 1'b1;

  // Decide next mode, counters and command pulses by the fixed priority order.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_to_nxt    = r_to;
    w_tick_nxt  = 1'b0;
    w_min_nxt   = 1'b0;
    w_hr_nxt    = 1'b0;
    w_clr_nxt   = 1'b0;

    if (!start) begin
      // Dropping start abandons everything, including any pulse due this cycle.
      w_state_nxt = ST_IDLE;
      w_presc_nxt = '0;
      w_to_nxt    = '0;
    end else if (r_state == ST_IDLE) begin
      // Buttons are ignored here; the first second starts from a clean prescaler.
      w_state_nxt = ST_RUN;
      w_presc_nxt = '0;
      w_to_nxt    = '0;
    end else begin
      w_presc_nxt = w_presc_adv;

      // Clear restarts the current second; it combines with a mode step.
      if (w_clr_edge) begin
        w_clr_nxt   = 1'b1;
        w_presc_nxt = '0;
      end

      if (w_mode_edge) begin
        // Mode step beats a simultaneous inc, which is dropped.
        w_to_nxt = '0;
        case (r_state)
          ST_RUN: begin
            w_state_nxt = ST_SET_MIN;
            w_clr_nxt   = 1'b1;
          end
          ST_SET_MIN: w_state_nxt = ST_SET_HR;
          default:    w_state_nxt = ST_RUN;
        endcase
      end else if (w_clr_edge) begin
        // Clear outranks inc and timeout; the prescaler restart means no wrap either.
        w_to_nxt = r_to;
      end else if (r_state == ST_RUN) begin
        // Inc is meaningless while running; only the seconds tick matters.
        w_tick_nxt = w_wrap;
      end else if (w_inc_edge) begin
        w_to_nxt = '0;
        if (r_state == ST_SET_MIN) begin
          w_min_nxt = 1'b1;
        end else begin
          w_hr_nxt = 1'b1;
        end
      end else if (w_wrap) begin
        // A full untouched second in a SET state counts towards the auto-return.
        if (w_to_inc == TO_LIMIT) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_to_nxt = w_to_inc;
        end
      end

      // Any way back into RUN starts a fresh second with no pending timeout.
      if ((w_state_nxt == ST_RUN) && (r_state != ST_RUN)) begin
        w_presc_nxt = '0;
        w_to_nxt    = '0;
      end
    end
  end

  // Commit FSM, counters and the registered command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_to      <= '0;
      r_tick    <= 1'b0;
      r_min_inc <= 1'b0;
      r_hr_inc  <= 1'b0;
      r_sec_clr <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_to      <= w_to_nxt;
      r_tick    <= w_tick_nxt;
      r_min_inc <= w_min_nxt;
      r_hr_inc  <= w_hr_nxt;
      r_sec_clr <= w_clr_nxt;
      r_running <= (w_state_nxt == ST_RUN);
    end
  end

  assign tick_1hz = r_tick;
  assign min_inc  = r_min_inc;
  assign hr_inc   = r_hr_inc;
  assign sec_clr  = r_sec_clr;
  assign mode     = r_state;
  assign running  = r_running;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller with a per-cycle reference model.
// Latency: model predicts the registered outputs one cycle after inputs are sampled.
// Backpressure: n/a.
module tb_clock_mode_controller;

  localparam int DIV = 4;
  localparam int TOT = 3;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn  = 1'b0;
  logic       clr_btn  = 1'b0;
  logic       tick_1hz;
  logic       min_inc;
  logic       hr_inc;
  logic       sec_clr;
  logic [1:0] mode;
  logic       running;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0..3, position within the current second, quiet seconds in SET.
  int   m_state = 0;
  int   m_phase = 0;
  int   m_quiet = 0;
  logic p_mode  = 1'b0;
  logic p_inc   = 1'b0;
  logic p_clr   = 1'b0;
  logic e_tick  = 1'b0;
  logic e_min   = 1'b0;
  logic e_hr    = 1'b0;
  logic e_clr   = 1'b0;

  clock_mode_controller #(
    .CLK_DIV       (DIV),
    .TIMEOUT_TICKS (TOT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .clr_btn  (clr_btn),
    .tick_1hz (tick_1hz),
    .min_inc  (min_inc),
    .hr_inc   (hr_inc),
    .sec_clr  (sec_clr),
    .mode     (mode),
    .running  (running)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Reference model, evaluated at each sampling edge and on async reset.
  initial begin : model
    logic em, ei, ec, wrapped;
    int   nxt;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state = 0; m_phase = 0; m_quiet = 0;
        p_mode = 0; p_inc = 0; p_clr = 0;
        e_tick = 0; e_min = 0; e_hr = 0; e_clr = 0;
      end else begin
        em = mode_btn && !p_mode;
        ei = inc_btn && !p_inc;
        ec = clr_btn && !p_clr;
        p_mode = mode_btn; p_inc = inc_btn; p_clr = clr_btn;
        e_tick = 0; e_min = 0; e_hr = 0; e_clr = 0;
        if (!start) begin
          m_state = 0; m_phase = 0; m_quiet = 0;
        end else if (m_state == 0) begin
          m_state = 1; m_phase = 0; m_quiet = 0;
        end else begin
          nxt     = m_state;
          wrapped = (m_phase == DIV - 1);
          m_phase = (m_phase + 1) % DIV;
          if (ec) begin
            e_clr = 1; m_phase = 0; wrapped = 0;
          end
          if (em) begin
            m_quiet = 0;
            if (m_state == 1) begin nxt = 2; e_clr = 1; end
            else if (m_state == 2) nxt = 3;
            else nxt = 1;
          end else if (!ec && ei && m_state != 1) begin
            m_quiet = 0;
            if (m_state == 2) e_min = 1; else e_hr = 1;
          end else if (!ec && m_state != 1 && wrapped) begin
            m_quiet = m_quiet + 1;
            if (m_quiet == TOT) nxt = 1;
          end else if (m_state == 1 && wrapped) begin
            e_tick = 1;
          end
          if (nxt == 1 && m_state != 1) begin
            m_phase = 0; m_quiet = 0;
          end
          m_state = nxt;
        end
      end
    end
  end

  // Every cycle, mid-period, compare all outputs against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("tick_1hz", {31'd0, tick_1hz}, {31'd0, e_tick});
      chk("min_inc", {31'd0, min_inc}, {31'd0, e_min});
      chk("hr_inc", {31'd0, hr_inc}, {31'd0, e_hr});
      chk("sec_clr", {31'd0, sec_clr}, {31'd0, e_clr});
      chk("mode", {30'd0, mode}, m_state);
      chk("running", {31'd0, running}, (m_state == 1) ? 32'd1 : 32'd0);
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin : stim
    repeat (3) step();
    chk("rst_mode", {30'd0, mode}, 0);
    chk("rst_running", {31'd0, running}, 0);
    chk("rst_tick", {31'd0, tick_1hz}, 0);
    chk("rst_sec_clr", {31'd0, sec_clr}, 0);
    rst_n = 1'b1;
    step(); step();
    chk("idle_mode", {30'd0, mode}, 0);

    // Enter RUN, ticks every 4 cycles.
    start = 1'b1; step();
    chk("entry_mode", {30'd0, mode}, 1);
    chk("entry_running", {31'd0, running}, 1);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("run_tick", {31'd0, tick_1hz}, (i % 4 == 0) ? 32'd1 : 32'd0);
    end

    // Held mode button: one step to SET_MIN, one sec_clr.
    mode_btn = 1'b1; step();
    chk("setmin_mode", {30'd0, mode}, 2);
    chk("setmin_clr", {31'd0, sec_clr}, 1);
    step();
    chk("setmin_clr_once", {31'd0, sec_clr}, 0);
    chk("setmin_hold", {30'd0, mode}, 2);
    step(); step(); step();
    chk("setmin_still", {30'd0, mode}, 2);

    // Two inc presses -> two min_inc pulses.
    mode_btn = 1'b0; inc_btn = 1'b1; step();
    chk("min_inc1", {31'd0, min_inc}, 1);
    chk("min_inc1_hr", {31'd0, hr_inc}, 0);
    inc_btn = 1'b0; step();
    chk("min_inc1_end", {31'd0, min_inc}, 0);
    inc_btn = 1'b1; step();
    chk("min_inc2", {31'd0, min_inc}, 1);
    inc_btn = 1'b0; step();
    mode_btn = 1'b1; step();
    chk("sethr_mode", {30'd0, mode}, 3);
    mode_btn = 1'b0; inc_btn = 1'b1; step();
    chk("hr_inc", {31'd0, hr_inc}, 1);
    chk("hr_inc_min", {31'd0, min_inc}, 0);
    inc_btn = 1'b0; step();

    // Timeout back to RUN after three untouched seconds.
    repeat (7) step();
    chk("to_before", {30'd0, mode}, 3);
    step();
    chk("to_mode", {30'd0, mode}, 1);
    chk("to_running", {31'd0, running}, 1);
    repeat (3) step();
    chk("to_tick_early", {31'd0, tick_1hz}, 0);
    step();
    chk("to_tick", {31'd0, tick_1hz}, 1);

    // Mode and inc together in SET_MIN: mode wins, inc dropped.
    mode_btn = 1'b1; step();
    chk("m2_mode", {30'd0, mode}, 2);
    mode_btn = 1'b0; step();
    mode_btn = 1'b1; inc_btn = 1'b1; step();
    chk("both_mode", {30'd0, mode}, 3);
    chk("both_min", {31'd0, min_inc}, 0);
    chk("both_hr", {31'd0, hr_inc}, 0);
    mode_btn = 1'b0; inc_btn = 1'b0; step();
    mode_btn = 1'b1; step();
    chk("hr_to_run", {30'd0, mode}, 1);
    mode_btn = 1'b0; step();
    mode_btn = 1'b1; step();
    chk("m3_mode", {30'd0, mode}, 2);
    mode_btn = 1'b0; step();

    // Start drop in SET_MIN with an inc edge pending.
    start = 1'b0; inc_btn = 1'b1; step();
    chk("drop_mode", {30'd0, mode}, 0);
    chk("drop_min", {31'd0, min_inc}, 0);
    chk("drop_running", {31'd0, running}, 0);
    inc_btn = 1'b0; start = 1'b1; step();
    chk("reentry_mode", {30'd0, mode}, 1);

    // Clear in RUN restarts the second.
    step(); step();
    clr_btn = 1'b1; step();
    chk("clr_pulse", {31'd0, sec_clr}, 1);
    chk("clr_mode", {30'd0, mode}, 1);
    clr_btn = 1'b0;
    for (int i = 4; i <= 7; i++) begin
      step();
      chk("clr_tick", {31'd0, tick_1hz}, (i == 7) ? 32'd1 : 32'd0);
    end

    // Clear and mode together: both apply.
    clr_btn = 1'b1; mode_btn = 1'b1; step();
    chk("clrmode_mode", {30'd0, mode}, 2);
    chk("clrmode_clr", {31'd0, sec_clr}, 1);
    clr_btn = 1'b0; mode_btn = 1'b0; step();
    mode_btn = 1'b1; step();
    mode_btn = 1'b0; step();
    mode_btn = 1'b1; step();
    chk("back_run", {30'd0, mode}, 1);
    mode_btn = 1'b0; step(); step();

    // Async reset mid-RUN.
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("arst_mode", {30'd0, mode}, 0);
    chk("arst_running", {31'd0, running}, 0);
    chk("arst_tick", {31'd0, tick_1hz}, 0);
    chk("arst_clr", {31'd0, sec_clr}, 0);
    step(); step();
    rst_n = 1'b1; step();

    // Clear ignored in IDLE; first tick four cycles after re-entry.
    start = 1'b1; clr_btn = 1'b1; step();
    chk("idle_clr_mode", {30'd0, mode}, 1);
    chk("idle_clr_pulse", {31'd0, sec_clr}, 0);
    clr_btn = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("rst_tick_seq", {31'd0, tick_1hz}, (i == 4) ? 32'd1 : 32'd0);
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
